// File: rtl/bfp_pkg.sv
// Shared widths, state encoding and exponent-merge helper for the block
// floating-point normalizer and its alignment shifter.
package bfp_pkg;

    localparam int NARROW_EXP = 4;
    localparam int NARROW_MAN = 10;
    localparam int WIDE_EXP   = 8;
    localparam int WIDE_MAN   = 23;
    localparam int SB_W       = 3;
    localparam int BLOCK      = 4;

    localparam int NARROW_W = 1 + NARROW_EXP + NARROW_MAN;
    localparam int WIDE_W   = 1 + WIDE_EXP + WIDE_MAN;
    localparam int EXP_EXT  = WIDE_EXP - NARROW_EXP;
    localparam int MAN_EXT  = WIDE_MAN - NARROW_MAN;
    localparam int BUF_W    = 1 + WIDE_EXP + NARROW_MAN;
    localparam int CNT_W    = $clog2(BLOCK);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Unbiased exponent in the wide signed domain: raw is unsigned, bias signed.
    function automatic logic signed [WIDE_EXP-1:0] mergedExp(
        input logic        [NARROW_EXP-1:0] raw,
        input logic signed [SB_W-1:0]       bias
    );
        logic signed [WIDE_EXP-1:0] rawExt;
        logic signed [WIDE_EXP-1:0] biasExt;
        rawExt  = {{EXP_EXT{1'b0}}, raw};
        biasExt = {{(WIDE_EXP - SB_W){bias[SB_W-1]}}, bias};
        return rawExt - biasExt;
    endfunction

endpackage

// File: rtl/bfp_align_shift.sv
// Re-expresses one buffered narrow element against the block exponent,
// right-aligning its mantissa and flushing it to zero when shifted out.
module bfp_align_shift
    import bfp_pkg::*;
(
    input  logic                       i_sign,
    input  logic        [NARROW_MAN-1:0] i_man,
    input  logic signed [WIDE_EXP-1:0] i_exp,
    input  logic signed [WIDE_EXP-1:0] i_maxExp,
    output logic        [WIDE_W-1:0]   o_elem
);

    localparam int SH_W = $clog2(WIDE_MAN);
    localparam logic signed [WIDE_EXP:0] DIFF_LIMIT = (WIDE_EXP + 1)'(WIDE_MAN);

    logic signed [WIDE_EXP:0] w_diff;
    logic        [WIDE_MAN-1:0] w_manExt;
    logic        [WIDE_MAN-1:0] w_aligned;

    // One extra bit on the difference keeps the subtraction from wrapping.
    always_comb begin
        w_diff    = {i_maxExp[WIDE_EXP-1], i_maxExp} - {i_exp[WIDE_EXP-1], i_exp};
        w_manExt  = {{MAN_EXT{1'b0}}, i_man};
        w_aligned = '0;
        if (w_diff >= 0 && w_diff < DIFF_LIMIT) begin
            w_aligned = w_manExt >> w_diff[SH_W-1:0];
        end
    end

    assign o_elem = {i_sign, i_maxExp, w_aligned};

endmodule

// File: rtl/bfp_block_normalizer.sv
// Buffers a block of narrow elements, tracks the largest merged exponent, then
// replays the block in wide format aligned to that shared exponent.
module bfp_block_normalizer
    import bfp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NARROW_W-1:0]      in_data,
    input  logic signed [SB_W-1:0]   shared_bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDE_W-1:0]        out_data,
    output logic                     out_last
);

    localparam logic signed [WIDE_EXP-1:0] EXP_MIN  = {1'b1, {(WIDE_EXP - 1){1'b0}}};
    localparam logic        [CNT_W-1:0]    CNT_LAST = CNT_W'(BLOCK - 1);

    state_t                     r_state;
    state_t                     w_stateNext;
    logic        [CNT_W-1:0]    r_cnt;
    logic signed [WIDE_EXP-1:0] r_maxExp;
    logic signed [SB_W-1:0]     r_bias;
    logic        [BUF_W-1:0]    r_buf [BLOCK];

    logic                       w_inFire;
    logic                       w_outFire;
    logic                       w_cntLast;
    logic signed [SB_W-1:0]     w_bias;
    logic signed [WIDE_EXP-1:0] w_expIn;
    logic        [BUF_W-1:0]    w_bufOut;
    logic        [WIDE_W-1:0]   w_alignOut;

    // Handshake outputs are gated by reset so nothing leaks while it is held.
    assign w_cntLast = (r_cnt == CNT_LAST);
    assign in_ready  = rst_n && (r_state == FILL);
    assign out_valid = rst_n && (r_state == DRAIN);
    assign out_last  = out_valid && w_cntLast;
    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = out_valid && out_ready;

    // Element 0 uses the live port bias; the rest reuse the value latched with it.
    assign w_bias  = (r_cnt == '0) ? shared_bias : r_bias;
    assign w_expIn = mergedExp(in_data[NARROW_W-2 -: NARROW_EXP], w_bias);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            FILL:    if (w_inFire && w_cntLast)  w_stateNext = DRAIN;
            DRAIN:   if (w_outFire && w_cntLast) w_stateNext = FILL;
            default: w_stateNext = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_maxExp <= EXP_MIN;
            r_bias   <= '0;
        end else if (w_inFire) begin
            r_cnt <= w_cntLast ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
                r_bias <= shared_bias;
            end
            if (r_cnt == '0 || w_expIn > r_maxExp) begin
                r_maxExp <= w_expIn;
            end
        end else if (w_outFire) begin
            r_cnt <= w_cntLast ? '0 : r_cnt + 1'b1;
            if (w_cntLast) begin
                r_maxExp <= EXP_MIN;
            end
        end
    end

    // Buffer needs no reset: a cleared counter and FILL state hide stale entries.
    always_ff @(posedge clk) begin
        if (w_inFire) begin
            r_buf[r_cnt] <= {in_data[NARROW_W-1], w_expIn, in_data[NARROW_MAN-1:0]};
        end
    end

    assign w_bufOut = r_buf[r_cnt];

    bfp_align_shift u_align (
        .i_sign   (w_bufOut[BUF_W-1]),
        .i_man    (w_bufOut[NARROW_MAN-1:0]),
        .i_exp    (w_bufOut[NARROW_MAN +: WIDE_EXP]),
        .i_maxExp (r_maxExp),
        .o_elem   (w_alignOut)
    );

    assign out_data = out_valid ? w_alignOut : '0;

endmodule

// File: tb/tb_bfp_block_normalizer.sv
// Directed scoreboard bench for bfp_block_normalizer: a reference model pushes
// expected wide elements when a block is accepted, drained outputs pop them.
module tb_bfp_block_normalizer;
    import bfp_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [NARROW_W-1:0]    in_data;
    logic signed [SB_W-1:0] shared_bias;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDE_W-1:0]      out_data;
    logic                   out_last;

    int nChecks = 0;
    int nFail   = 0;

    logic [WIDE_W:0]        expQ [$];
    logic [NARROW_W-1:0]    blkElem [BLOCK];
    logic signed [SB_W-1:0] blkBias;
    int                     fillCount = 0;

    always #5 clk = ~clk;

    bfp_block_normalizer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .shared_bias (shared_bias),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    function automatic logic [NARROW_W-1:0] mk(input logic s, input logic [3:0] r,
                                               input logic [9:0] mm);
        return {s, r, mm};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: block exponent from element 0's bias, shift by distance to max.
    task automatic pushExpected();
        int                  expI [BLOCK];
        int                  maxE;
        int                  diff;
        logic [WIDE_MAN-1:0] manExt;
        logic [WIDE_MAN-1:0] man;
        logic [WIDE_EXP-1:0] be;
        maxE = 0;
        for (int i = 0; i < BLOCK; i++) begin
            expI[i] = int'(blkElem[i][NARROW_W-2 -: NARROW_EXP]) - int'(blkBias);
            if (i == 0 || expI[i] > maxE) maxE = expI[i];
        end
        be = maxE[WIDE_EXP-1:0];
        for (int i = 0; i < BLOCK; i++) begin
            diff   = maxE - expI[i];
            manExt = WIDE_MAN'(blkElem[i][NARROW_MAN-1:0]);
            man    = (diff >= WIDE_MAN) ? '0 : (manExt >> diff);
            expQ.push_back({(i == BLOCK - 1), blkElem[i][NARROW_W-1], be, man});
        end
    endtask

    task automatic recordElem(input logic [NARROW_W-1:0] elem, input logic signed [SB_W-1:0] bias);
        if (fillCount == 0) blkBias = bias;
        blkElem[fillCount] = elem;
        fillCount++;
        if (fillCount == BLOCK) begin
            pushExpected();
            fillCount = 0;
        end
    endtask

    task automatic applyStimulus(input logic [NARROW_W-1:0] elem,
                                 input logic signed [SB_W-1:0] bias, input int gap);
        int waitCyc = 0;
        repeat (gap) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = '0;
        end
        @(posedge clk); #1;
        in_valid    = 1'b1;
        in_data     = elem;
        shared_bias = bias;
        @(negedge clk);
        while (!in_ready && waitCyc < 32) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!in_ready) begin
            checkOutput("fillTimeout", in_ready, 1);
        end else begin
            checkOutput("fillOutValid", out_valid, 0);
            recordElem(elem, bias);
        end
    endtask

    task automatic sendBlock(input logic [NARROW_W-1:0] els [BLOCK],
                             input logic signed [SB_W-1:0] bs [BLOCK], input int gap);
        for (int i = 0; i < BLOCK; i++) begin
            applyStimulus(els[i], bs[i], (i == 0) ? 0 : gap);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latencyValid", out_valid, 1);
        checkOutput("drainStartInReady", in_ready, 0);
    endtask

    task automatic drainBlock(input int nOut, input logic [15:0] stallMask, input logic checkRelease);
        int              got = 0;
        int              cyc = 0;
        logic            haveHeld = 1'b0;
        logic [WIDE_W:0] held;
        logic [WIDE_W:0] obsv;
        logic [WIDE_W:0] expV;
        while (got < nOut && cyc < 64) begin
            @(posedge clk); #1;
            out_ready = (cyc < 16) ? !stallMask[cyc] : 1'b1;
            @(negedge clk);
            obsv = {out_last, out_data};
            if (!out_valid) begin
                checkOutput("drainValid", out_valid, 1);
            end else begin
                checkOutput("drainInReady", in_ready, 0);
                if (haveHeld) checkOutput("holdStable", obsv, held);
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("queueUnderflow", expQ.size(), 1);
                    end else begin
                        expV = expQ.pop_front();
                        checkOutput($sformatf("outElem%0d", got), obsv, expV);
                    end
                    got++;
                    haveHeld = 1'b0;
                end else begin
                    held     = obsv;
                    haveHeld = 1'b1;
                end
            end
            cyc++;
        end
        checkOutput("drainCount", got, nOut);
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (checkRelease) begin
            @(negedge clk);
            checkOutput("releaseInReady", in_ready, 1);
            checkOutput("releaseOutValid", out_valid, 0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        shared_bias = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstInReady", in_ready, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstOutLast", out_last, 0);
        checkOutput("rstOutData", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstInReady", in_ready, 1);
        checkOutput("postRstOutValid", out_valid, 0);

        $display("[TB] basic block, bias 1");
        sendBlock('{mk(1'b0, 4'd3, 10'h3FF), mk(1'b1, 4'd5, 10'h3FF),
                    mk(1'b0, 4'd2, 10'h3FF), mk(1'b0, 4'd5, 10'h3FF)},
                  '{3'b001, 3'b001, 3'b001, 3'b001}, 0);
        drainBlock(4, 16'h0000, 1'b1);

        $display("[TB] negative bias, shift-out flush");
        sendBlock('{mk(1'b0, 4'd15, 10'h200), mk(1'b0, 4'd0, 10'h200),
                    mk(1'b0, 4'd0, 10'h200), mk(1'b0, 4'd0, 10'h200)},
                  '{3'b110, 3'b110, 3'b110, 3'b110}, 0);
        drainBlock(4, 16'h0000, 1'b1);

        $display("[TB] output backpressure");
        sendBlock('{mk(1'b1, 4'd7, 10'h155), mk(1'b0, 4'd4, 10'h2AA),
                    mk(1'b1, 4'd9, 10'h0F0), mk(1'b0, 4'd1, 10'h001)},
                  '{3'b000, 3'b000, 3'b000, 3'b000}, 0);
        drainBlock(4, 16'h001C, 1'b1);

        $display("[TB] input gaps");
        sendBlock('{mk(1'b0, 4'd10, 10'h3FF), mk(1'b1, 4'd12, 10'h123),
                    mk(1'b0, 4'd3, 10'h200), mk(1'b1, 4'd12, 10'h3FE)},
                  '{3'b101, 3'b101, 3'b101, 3'b101}, 1);
        drainBlock(4, 16'h0000, 1'b1);

        $display("[TB] bias change after element 0");
        sendBlock('{mk(1'b0, 4'd3, 10'h3FF), mk(1'b1, 4'd5, 10'h3FF),
                    mk(1'b0, 4'd2, 10'h3FF), mk(1'b0, 4'd5, 10'h3FF)},
                  '{3'b001, 3'b011, 3'b011, 3'b011}, 0);
        drainBlock(4, 16'h0000, 1'b1);

        $display("[TB] reset mid-drain");
        sendBlock('{mk(1'b1, 4'd8, 10'h0AB), mk(1'b0, 4'd6, 10'h3C3),
                    mk(1'b1, 4'd14, 10'h011), mk(1'b0, 4'd2, 10'h2F0)},
                  '{3'b010, 3'b010, 3'b010, 3'b010}, 0);
        drainBlock(2, 16'h0000, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstOutValid", out_valid, 0);
        checkOutput("midRstOutLast", out_last, 0);
        checkOutput("midRstOutData", out_data, 0);
        checkOutput("midRstInReady", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expQ.delete();
        fillCount = 0;
        @(negedge clk);
        checkOutput("midRstRelInReady", in_ready, 1);
        checkOutput("midRstRelOutValid", out_valid, 0);
        sendBlock('{mk(1'b0, 4'd1, 10'h100), mk(1'b1, 4'd2, 10'h155),
                    mk(1'b0, 4'd4, 10'h3FF), mk(1'b1, 4'd3, 10'h001)},
                  '{3'b010, 3'b010, 3'b010, 3'b010}, 0);
        drainBlock(4, 16'h0000, 1'b1);

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
